dot_fp_blk: RTL
===============

DOT_FP_BLK -- requirements
Module: dot_fp_blk

Interface
REQ-001 The module SHALL have parameter exp_width, default 5, meaning the element exponent field width.
REQ-002 The module SHALL have parameter man_width, default 2, meaning the element mantissa field width.
REQ-003 The module SHALL have parameter lanes, default 4, meaning the number of element pairs per beat (power of 2, at least 1).
REQ-004 The module SHALL have parameter blk_size, default 32, meaning the elements per block (power of 2, multiple of lanes).
REQ-005 The module SHALL define bit_width = 1+exp_width+man_width, prd_width = 2*((1<<exp_width)+man_width), acc_width = prd_width+$clog2(blk_size), beats = blk_size/lanes.
REQ-006 The module SHALL have port clk, input, 1 bit, meaning the single clock; all state SHALL be on its rising edge.
REQ-007 The module SHALL have port rst, input, 1 bit, meaning the reset; it SHALL be asynchronous and active-high.
REQ-008 The module SHALL have port i_valid, input, 1 bit, meaning the input beat is valid.
REQ-009 The module SHALL have port o_ready, output, 1 bit, meaning the module accepts an input beat.
REQ-010 The module SHALL have port i_op0, input, lanes*bit_width bits, meaning the operand-0 elements (lane k at bits [k*bit_width +: bit_width]).
REQ-011 The module SHALL have port i_op1, input, lanes*bit_width bits, meaning the operand-1 elements, packed as i_op0.
REQ-012 The module SHALL have port o_valid, output, 1 bit, meaning o_dot holds a completed block result.
REQ-013 The module SHALL have port i_ready, input, 1 bit, meaning the downstream accepts the result.
REQ-014 The module SHALL have port o_dot, output, acc_width bits signed, meaning the block dot product.

Function
REQ-015 Element decoding SHALL be: sign = MSB; e = exponent field; m = mantissa field; magnitude = m if e==0, else ({1,m} << (e-1)); all codes finite, no inf/NaN; -0 equals 0.
REQ-016 Each lane product SHALL be the exact signed integer sign0^sign1 * mag0*mag1 in prd_width bits, i.e. real product divided by (min subnormal)^2.
REQ-017 o_dot SHALL be the exact two's-complement sum of all blk_size lane products of one block, with no rounding, saturation or overflow.
REQ-018 A beat SHALL be accepted on a rising edge with i_valid && o_ready.
REQ-019 A pipeline enable SHALL be defined as en = !o_valid || i_ready, and o_ready SHALL equal en.
REQ-020 The pipeline SHALL have three stages, all advancing only when en is high: S1 registers lane decode and products; S2 registers the lane adder-tree sum; S3 is the accumulator.
REQ-021 A beat counter SHALL count accepted beats 0..beats-1 and wrap to 0 after beat beats-1; the first beat of a block SHALL load the accumulator, replacing its contents rather than adding to them.
REQ-022 Latency SHALL be 3 cycles: o_valid SHALL rise 3 rising edges after the final beat is accepted, given no stall.
REQ-023 o_valid and o_dot SHALL hold stable while o_valid && !i_ready.
REQ-024 Back-to-back blocks SHALL sustain one beat per cycle with no bubble while i_ready is high.
REQ-025 Gaps in i_valid SHALL insert bubbles that are tracked by per-stage valid bits; bubbles SHALL NOT alter the accumulator or the counter.
REQ-026 When beats == 1, every beat SHALL be a complete block.
REQ-027 When the result is accepted in the same cycle that the next block's final sum reaches S3, the new result SHALL replace it with no loss.

Reset
REQ-028 While rst is high, o_valid SHALL be 0, o_dot SHALL be 0, the beat counter SHALL be 0, all stage valid bits SHALL be 0, and o_ready SHALL be 1.
REQ-029 A reset asserted mid-block SHALL discard the partial block; the first beat accepted after reset SHALL be beat 0 of a new block.

Verification
REQ-030 Defaults; all lanes op0 = 8'h04 (1.0 min normal = mag 4) and op1 = 8'h04 for 8 beats with i_ready = 1 -> o_dot = 32*16 = 512, o_valid rises 3 cycles after beat 8.
REQ-031 Defaults; op0 = 8'h01 and op1 = 8'h81 in every lane -> o_dot = -32; in a separate block, op0 = 8'h7F and op1 = 8'h7F in all lanes -> exact 32*(7<<30)^2, with no overflow of acc_width.
REQ-032 Two back-to-back blocks, the first all 8'h04 x 8'h04 and the second all 8'h00 x anything -> results 512 then 0 on consecutive o_valid pulses 8 cycles apart; o_ready stays 1.
REQ-033 Hold i_ready = 0 while the result is pending -> o_ready = 0, o_dot is stable and no beat is accepted; release -> streaming resumes and results are correct.
REQ-034 Assert rst after 3 beats, deassert it, then send a full block of 8'h04 x 8'h04 -> o_dot = 512, not 512 + 3*64.
REQ-035 Exhaustive check with lanes = 1 and blk_size = 1: sweep all 2^bit_width x 2^bit_width operand pairs -> o_dot equals the real reference product, scaled as in REQ-016, for every pair.

Source files
------------

// File: rtl/dot_fp_blk.sv
// rtl/dot_fp_blk.sv - streaming block dot product of small floating-point elements
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   i_valid, o_ready  input beat handshake (lanes element pairs per beat)
//   i_op0, i_op1      packed elements, lane k at [k*bit_width +: bit_width]
//   o_valid, i_ready  result handshake
//   o_dot             exact signed sum of blk_size products, in units of
//                     (min subnormal)^2
module dot_fp_blk #(
    parameter int exp_width = 5,
    parameter int man_width = 2,
    parameter int lanes     = 4,
    parameter int blk_size  = 32
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          i_valid,
    output logic                                          o_ready,
    input  logic [lanes*(1+exp_width+man_width)-1:0]      i_op0,
    input  logic [lanes*(1+exp_width+man_width)-1:0]      i_op1,
    output logic                                          o_valid,
    input  logic                                          i_ready,
    output logic signed [2*((1<<exp_width)+man_width)+$clog2(blk_size)-1:0] o_dot
);

    localparam int bit_width = 1 + exp_width + man_width;
    localparam int prd_width = 2 * ((1 << exp_width) + man_width);
    localparam int acc_width = prd_width + $clog2(blk_size);
    localparam int beats     = blk_size / lanes;
    // Widest magnitude is {1,m} << (2^exp_width - 2); half of prd_width
    // leaves headroom so the signed product never overflows.
    localparam int mag_width = prd_width / 2;
    localparam int cnt_width = (beats > 1) ? $clog2(beats) : 1;
    localparam logic [cnt_width-1:0] last_beat = cnt_width'(beats - 1);

    function automatic logic [mag_width-1:0] elem_mag(input logic [bit_width-1:0] c);
        logic [exp_width-1:0] e;
        logic [man_width-1:0] m;
        e = c[bit_width-2 -: exp_width];
        m = c[man_width-1:0];
        if (e == '0) begin
            elem_mag = mag_width'(m);
        end else begin
            elem_mag = mag_width'({1'b1, m}) << (e - exp_width'(1));
        end
    endfunction

    function automatic logic signed [prd_width-1:0] lane_prd(input logic [bit_width-1:0] a,
                                                             input logic [bit_width-1:0] b);
        logic [prd_width-1:0] p;
        p = prd_width'(elem_mag(a)) * prd_width'(elem_mag(b));
        if (a[bit_width-1] ^ b[bit_width-1]) begin
            p = -p;
        end
        lane_prd = signed'(p);
    endfunction

    logic en;
    logic accept;

    logic [cnt_width-1:0]        cnt_q, cnt_d;
    logic                        v1_q, v1_d;
    logic                        first1_q, first1_d;
    logic                        last1_q, last1_d;
    logic signed [prd_width-1:0] prd_q [lanes];
    logic signed [prd_width-1:0] prd_d [lanes];
    logic                        v2_q, v2_d;
    logic                        first2_q, first2_d;
    logic                        last2_q, last2_d;
    logic signed [acc_width-1:0] sum2_q, sum2_d;
    logic signed [acc_width-1:0] acc_q, acc_d;
    logic                        o_valid_q, o_valid_d;

    // The whole pipe freezes while a finished result waits for the consumer.
    assign en      = !o_valid_q || i_ready;
    assign accept  = i_valid && en;
    assign o_ready = en;
    assign o_valid = o_valid_q;
    assign o_dot   = acc_q;

    // S1: beat position, lane decode and products
    always_comb begin
        cnt_d    = cnt_q;
        v1_d     = v1_q;
        first1_d = first1_q;
        last1_d  = last1_q;
        for (int k = 0; k < lanes; k++) begin
            prd_d[k] = prd_q[k];
        end
        if (accept) begin
            cnt_d = (cnt_q == last_beat) ? '0 : cnt_q + cnt_width'(1);
        end
        if (en) begin
            v1_d     = i_valid;
            first1_d = (cnt_q == '0);
            last1_d  = (cnt_q == last_beat);
            for (int k = 0; k < lanes; k++) begin
                prd_d[k] = lane_prd(i_op0[k*bit_width +: bit_width],
                                    i_op1[k*bit_width +: bit_width]);
            end
        end
    end

    // S2: lane sum
    always_comb begin
        v2_d     = v2_q;
        first2_d = first2_q;
        last2_d  = last2_q;
        sum2_d   = sum2_q;
        if (en) begin
            v2_d     = v1_q;
            first2_d = first1_q;
            last2_d  = last1_q;
            sum2_d   = '0;
            for (int k = 0; k < lanes; k++) begin
                sum2_d = sum2_d + acc_width'(prd_q[k]);
            end
        end
    end

    // S3: accumulator; a bubble leaves it untouched and produces no result
    always_comb begin
        acc_d     = acc_q;
        o_valid_d = o_valid_q;
        if (en) begin
            o_valid_d = v2_q && last2_q;
            if (v2_q) begin
                acc_d = first2_q ? sum2_q : acc_q + sum2_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            v1_q      <= 1'b0;
            first1_q  <= 1'b0;
            last1_q   <= 1'b0;
            for (int k = 0; k < lanes; k++) begin
                prd_q[k] <= '0;
            end
            v2_q      <= 1'b0;
            first2_q  <= 1'b0;
            last2_q   <= 1'b0;
            sum2_q    <= '0;
            acc_q     <= '0;
            o_valid_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            v1_q      <= v1_d;
            first1_q  <= first1_d;
            last1_q   <= last1_d;
            for (int k = 0; k < lanes; k++) begin
                prd_q[k] <= prd_d[k];
            end
            v2_q      <= v2_d;
            first2_q  <= first2_d;
            last2_q   <= last2_d;
            sum2_q    <= sum2_d;
            acc_q     <= acc_d;
            o_valid_q <= o_valid_d;
        end
    end

endmodule
